note_blitter: RTL

- Consumer of the note sprite ROM: takes a "draw note" request (type, top-left x/y, ink/erase) and walks the ROM sprite row by row, column by column.
- Emits one 1-bit framebuffer write per set sprite pixel; off-screen pixels are clipped.
- Sits between the score layout/sequencing logic and the VGA framebuffer write port, driving the ROM's note type and row address.

---
 rtl/note_blitter_pkg.sv | 28 ++
 rtl/note_blitter_if.sv | 49 ++++
 rtl/note_blitter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/note_blitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_blitter_pkg
// Description : Shared note sprite constants (sprite geometry, note type
//               codes) and the blitter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package note_blitter_pkg;

  // Sprite geometry, shared with the note sprite ROM
  localparam int NOTE_WIDTH  = 28;
  localparam int NOTE_HEIGHT = 24;

  // Note type codes presented to the ROM noteType input
  localparam logic [1:0] QUARTER_NOTE = 2'd0;
  localparam logic [1:0] HALF_NOTE    = 2'd1;
  localparam logic [1:0] WHOLE_NOTE   = 2'd2;

  // Blitter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/note_blitter_if.sv
`default_nettype none
// ============================================================================
// Module      : note_blitter_if
// Description : Bundle of the blitter's request, ROM and framebuffer signals.
//               slave  : the blitter itself.
//               master : the surroundings (sequencer, ROM, framebuffer).
//   req_*          draw request handshake and fields
//   rom_note_type  ROM note type select; rom_addr ROM row; rom_data ROM row bits
//   fb_*           framebuffer write port (fb_ready = write accepted)
//   busy / done    status; done is a one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface note_blitter_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  import note_blitter_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_type;
  logic [X_W-1:0]        req_x;
  logic [Y_W-1:0]        req_y;
  logic                  req_erase;
  logic [1:0]            rom_note_type;
  logic [4:0]            rom_addr;
  logic [NOTE_WIDTH-1:0] rom_data;
  logic                  fb_we;
  logic [X_W-1:0]        fb_x;
  logic [Y_W-1:0]        fb_y;
  logic                  fb_wdata;
  logic                  fb_ready;
  logic                  busy;
  logic                  done;

  modport slave (
    input  req_valid, req_type, req_x, req_y, req_erase, rom_data, fb_ready,
    output req_ready, rom_note_type, rom_addr, fb_we, fb_x, fb_y, fb_wdata,
           busy, done
  );

  modport master (
    output req_valid, req_type, req_x, req_y, req_erase, rom_data, fb_ready,
    input  req_ready, rom_note_type, rom_addr, fb_we, fb_x, fb_y, fb_wdata,
           busy, done
  );

endinterface
`default_nettype wire

// File: rtl/note_blitter.sv
`default_nettype none
// ============================================================================
// Module      : note_blitter
// Description : Draws one note sprite from the note ROM into a 1-bit
//               framebuffer. Walks the sprite row by row (one FETCH cycle
//               per row to latch the ROM bitmap, then one WRITE cycle per
//               column), emitting a write per set pixel that lands on screen.
//   clk, reset     clock; asynchronous active-high reset
//   bus (slave)    request handshake, ROM row interface, framebuffer port,
//                  busy/done status
// Revision    : 1.0 - initial release
// ============================================================================
module note_blitter
  import note_blitter_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic            clk,
  input  logic            reset,
  note_blitter_if.slave   bus
);

  localparam int            CW         = 5;
  localparam logic [CW-1:0] LAST_COL   = CW'(NOTE_WIDTH - 1);
  localparam logic [CW-1:0] LAST_ROW   = CW'(NOTE_HEIGHT - 1);
  localparam logic [X_W:0]  SCREEN_W_L = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]  SCREEN_H_L = (Y_W + 1)'(SCREEN_H);

  blit_state_t           state;
  blit_state_t           state_next;
  logic [1:0]            type_q;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic                  ink_q;
  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  logic [NOTE_WIDTH-1:0] row_bits;

  logic                  pix_bit;
  logic [CW-1:0]         bit_idx;
  logic [X_W:0]          px;
  logic [Y_W:0]          py;
  logic                  we;
  logic                  advance;

  // MSB of the row bitmap is the leftmost column
  assign bit_idx = LAST_COL - col;
  assign pix_bit = row_bits[bit_idx];

  // One extra bit so coordinates past the screen edge never wrap on-screen
  assign px = {1'b0, x_q} + {{(X_W + 1 - CW){1'b0}}, col};
  assign py = {1'b0, y_q} + {{(Y_W + 1 - CW){1'b0}}, row};

  assign we      = (state == ST_WRITE) && pix_bit &&
                   (px < SCREEN_W_L) && (py < SCREEN_H_L);
  // A pending write holds the column until the framebuffer takes it;
  // clear or clipped pixels move on every cycle
  assign advance = (state == ST_WRITE) && (!we || bus.fb_ready);

  assign bus.req_ready     = (state == ST_IDLE);
  assign bus.busy          = (state != ST_IDLE);
  assign bus.done          = (state == ST_DONE);
  assign bus.rom_note_type = type_q;
  assign bus.rom_addr      = row;
  assign bus.fb_we         = we;
  assign bus.fb_x          = px[X_W-1:0];
  assign bus.fb_y          = py[Y_W-1:0];
  assign bus.fb_wdata      = ink_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (bus.req_valid) state_next = ST_FETCH;
      ST_FETCH: state_next = ST_WRITE;
      ST_WRITE: begin
        if (advance && (col == LAST_COL)) begin
          state_next = (row == LAST_ROW) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_q   <= 2'd0;
      x_q      <= '0;
      y_q      <= '0;
      ink_q    <= 1'b0;
      row      <= '0;
      col      <= '0;
      row_bits <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            type_q <= bus.req_type;
            x_q    <= bus.req_x;
            y_q    <= bus.req_y;
            ink_q  <= ~bus.req_erase;
            row    <= '0;
            col    <= '0;
          end
        end
        ST_FETCH: begin
          row_bits <= bus.rom_data;
          col      <= '0;
        end
        ST_WRITE: begin
          if (advance) begin
            if (col == LAST_COL) begin
              col <= '0;
              if (row != LAST_ROW) row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
